// File: rtl/jk_button_driver.sv
// jk_button_driver: debounces raw set/reset/toggle buttons into single-cycle J/K
// command pulses and keeps a shadow of flip-flop Q. Define JK_DRV_CHECK_EN to add Q feedback checking.
module jk_button_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  input  logic btn_toggle,
  input  logic q_fb,
  output logic J,
  output logic K,
  output logic busy,
  output logic expected_q,
  output logic mismatch
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NB = 3;
  // Button index doubles as service priority: lower index wins.
  localparam int unsigned B_RST = 0;
  localparam int unsigned B_SET = 1;
  localparam int unsigned B_TGL = 2;

`ifdef JK_DRV_CHECK_EN
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK} state_t;
`else
  typedef enum logic {S_IDLE, S_DRIVE} state_t;
`endif

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] rise;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  state_t        state_q;
  logic [NB-1:0] pending_q;
  logic [NB-1:0] grant;
  logic          J_q, K_q, busy_q, eq_q;

  assign btn_raw = {btn_toggle, btn_set, btn_reset};

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) deb_d[i] = ~deb_q[i];
        else                                  cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == S_IDLE) begin
      if      (pending_q[B_RST]) grant[B_RST] = 1'b1;
      else if (pending_q[B_SET]) grant[B_SET] = 1'b1;
      else if (pending_q[B_TGL]) grant[B_TGL] = 1'b1;
    end
  end

`ifdef JK_DRV_CHECK_EN
  logic [SW-1:0] settle_q;
  logic          mm_q;
  assign mismatch = mm_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      J_q       <= 1'b0;
      K_q       <= 1'b0;
      busy_q    <= 1'b0;
      eq_q      <= 1'b1;
`ifdef JK_DRV_CHECK_EN
      settle_q  <= '0;
      mm_q      <= 1'b0;
`endif
    end else begin
      // New presses merge into pending even while a command is in flight.
      pending_q <= (pending_q & ~grant) | rise;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            state_q <= S_DRIVE;
            busy_q  <= 1'b1;
            if (grant[B_RST]) begin
              J_q  <= 1'b0;
              K_q  <= 1'b1;
              eq_q <= 1'b0;
            end else if (grant[B_SET]) begin
              J_q  <= 1'b1;
              K_q  <= 1'b0;
              eq_q <= 1'b1;
            end else begin
              J_q  <= 1'b1;
              K_q  <= 1'b1;
              eq_q <= ~eq_q;
            end
          end
        end
        S_DRIVE: begin
          J_q <= 1'b0;
          K_q <= 1'b0;
`ifdef JK_DRV_CHECK_EN
          state_q  <= S_SETTLE;
          settle_q <= '0;
`else
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`endif
        end
`ifdef JK_DRV_CHECK_EN
        S_SETTLE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_q  <= S_CHECK;
          else                                    settle_q <= settle_q + 1'b1;
        end
        S_CHECK: begin
          if (q_fb != eq_q) mm_q <= 1'b1;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign J          = J_q;
  assign K          = K_q;
  assign busy       = busy_q;
  assign expected_q = eq_q;

endmodule

// File: tb/tb_jk_button_driver.sv
// Directed bench for jk_button_driver with a JK flip-flop model on the feedback path.
module tb_jk_button_driver;

  localparam int unsigned DEB = 4;
  localparam int unsigned SET = 1;
`ifdef JK_DRV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bs = 1'b0, br = 1'b0, bt = 1'b0;
  logic q_fb, J, K, busy, eq, mm;
  logic ff_q = 1'b1, ff_load = 1'b0, ff_val = 1'b0;
  logic q_ovr = 1'b0, q_ovr_val = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [1:0] pulses[$];
  int unsigned adj = 0;
  int unsigned busy_seen = 0;

  jk_button_driver #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst(rst), .btn_set(bs), .btn_reset(br), .btn_toggle(bt),
    .q_fb(q_fb), .J(J), .K(K), .busy(busy), .expected_q(eq), .mismatch(mm)
  );

  always #5 clk = ~clk;

  assign q_fb = q_ovr ? q_ovr_val : ff_q;

  // Downstream JK flip-flop: not reset by rst, preloadable by the bench.
  always @(posedge clk) begin
    if (ff_load) ff_q <= ff_val;
    else case ({J, K})
      2'b10:   ff_q <= 1'b1;
      2'b01:   ff_q <= 1'b0;
      2'b11:   ff_q <= ~ff_q;
      default: ;
    endcase
  end

  typedef struct {
    logic rst, bs, br, bt;
    logic ej, ek, eb, eq;
  } vec_t;

  function automatic vec_t mk(input logic r, s, rs, t, j, k, b, e);
    vec_t v;
    v.rst = r; v.bs = s; v.br = rs; v.bt = t;
    v.ej = j; v.ek = k; v.eb = b; v.eq = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic watch(input int unsigned n);
    logic [1:0] prev_jk;
    prev_jk = 2'b00;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if ({J, K} != 2'b00) begin
        pulses.push_back({J, K});
        if (prev_jk != 2'b00) adj++;
      end
      if (busy) busy_seen++;
      prev_jk = {J, K};
    end
  endtask

  task automatic do_reset(input logic preload, input logic pv);
    rst = 1'b1; bs = 1'b0; br = 1'b0; bt = 1'b0; q_ovr = 1'b0;
    ff_load = preload; ff_val = pv;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ff_load = 1'b0;
    pulses.delete(); adj = 0; busy_seen = 0;
  endtask

  task automatic wait_jk(output logic found, output int unsigned cyc);
    found = 1'b0;
    cyc = 0;
    for (int unsigned k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ({J, K} != 2'b00) begin
        found = 1'b1;
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    logic found;
    int unsigned cyc;
    logic [1:0] p;
    logic [0:3] glitch;

    // Set press held from cycle 0 with the flip-flop preloaded to Q=0.
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 1, 0, 1, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, CHK, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, CHK, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; bs = tbl[i].bs; br = tbl[i].br; bt = tbl[i].bt;
      ff_load = (i == 0); ff_val = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d_J", i), J, tbl[i].ej);
      check($sformatf("row%0d_K", i), K, tbl[i].ek);
      check($sformatf("row%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("row%0d_expq", i), eq, tbl[i].eq);
      check($sformatf("row%0d_mm", i), mm, 1'b0);
    end
    ff_load = 1'b0;
    check("set_ffq", ff_q, 1'b1);

    // Single-cycle bounces on toggle must be ignored.
    do_reset(1'b0, 1'b0);
    glitch = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bt = glitch[i];
      watch(1);
    end
    bt = 1'b0;
    watch(20);
    check("glitch_pulses", pulses.size(), 0);
    check("glitch_busy", busy_seen, 0);
    check("glitch_expq", eq, 1'b1);

    // Set and reset debouncing together: reset served first.
    do_reset(1'b1, 1'b1);
    bs = 1'b1; br = 1'b1;
    watch(30);
    check("simul_count", pulses.size(), 2);
    p = (pulses.size() > 0) ? pulses[0] : 2'bxx;
    check("simul_first", p, 2'b01);
    p = (pulses.size() > 1) ? pulses[1] : 2'bxx;
    check("simul_second", p, 2'b10);
    check("simul_width", adj, 0);
    check("simul_expq", eq, 1'b1);
    check("simul_ffq", ff_q, 1'b1);
    check("simul_mm", mm, 1'b0);
    bs = 1'b0; br = 1'b0;
    watch(10);

    // Three separate toggle presses from Q=1.
    do_reset(1'b1, 1'b1);
    repeat (3) begin
      bt = 1'b1;
      watch(12);
      bt = 1'b0;
      watch(12);
    end
    check("tgl_count", pulses.size(), 3);
    for (int i = 0; i < 3; i++) begin
      p = (pulses.size() > i) ? pulses[i] : 2'bxx;
      check($sformatf("tgl_pulse%0d", i), p, 2'b11);
    end
    check("tgl_width", adj, 0);
    check("tgl_ffq", ff_q, 1'b0);
    check("tgl_expq", eq, 1'b0);
    check("tgl_mm", mm, 1'b0);

    // Reset during DRIVE with reset button held; latency check from cycle 0.
    do_reset(1'b0, 1'b0);
    br = 1'b1;
    wait_jk(found, cyc);
    check("rstdrv_seen", found, 1'b1);
    check("first_latency", cyc, DEB + 4);
    check("rstdrv_jk", {J, K}, 2'b01);
    check("rstdrv_expq_pre", eq, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstdrv_J", J, 1'b0);
    check("rstdrv_K", K, 1'b0);
    check("rstdrv_busy", busy, 1'b0);
    check("rstdrv_expq", eq, 1'b1);
    wait_jk(found, cyc);
    check("rstdrv_again", found, 1'b1);
    check("rstdrv_latency", cyc, DEB + 4);
    check("rstdrv_jk2", {J, K}, 2'b01);
    br = 1'b0;
    pulses.delete(); adj = 0;
    watch(15);
    check("rstdrv_no_extra", pulses.size(), 0);

    // Feedback forced low after a set command.
    do_reset(1'b0, 1'b0);
    bs = 1'b1;
    wait_jk(found, cyc);
    check("mm_set_seen", found, 1'b1);
    q_ovr = 1'b1; q_ovr_val = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mm_c1", mm, 1'b0);
    @(posedge clk); @(negedge clk);
    check("mm_c2", mm, 1'b0);
    @(posedge clk); @(negedge clk);
    check("mm_c3", mm, CHK);
    bs = 1'b0;
    watch(10);
    check("mm_sticky", mm, CHK);
    do_reset(1'b0, 1'b0);
    check("mm_cleared", mm, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_button_driver.md
Name: jk_button_driver

Overview:
- Upstream control stage for the JK flip-flop chip: turns three bouncy Wokwi pushbuttons (set, reset, toggle) into clean, single-cycle J/K command pulses.
- Debounces each button, queues one command per press, and drives J/K one command at a time.
- Keeps a shadow model of the flip-flop state and, optionally, checks the model against the flip-flop's Q output fed back.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must hold a new level before it is accepted; legal range ≥2; counter width is $clog2(DEBOUNCE_CYCLES+1).
- SETTLE_CYCLES, 1: wait cycles after the J/K pulse before q_fb is sampled; legal range ≥1.

Ports:
- clk  input  1  system clock; this block and the downstream flip-flop share it.
- rst  input  1  reset; synchronous, active-high.
- btn_set  input  1  raw set button, asynchronous, bouncy.
- btn_reset  input  1  raw reset button, asynchronous, bouncy.
- btn_toggle  input  1  raw toggle button, asynchronous, bouncy.
- q_fb  input  1  Q of the downstream flip-flop.
- J  output  1  J command to the flip-flop, registered.
- K  output  1  K command to the flip-flop, registered.
- busy  output  1  high while any state other than IDLE is active.
- expected_q  output  1  shadow model of flip-flop Q.
- mismatch  output  1  sticky error flag; q_fb differed from expected_q at a check.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: J=0, K=0, busy=0, expected_q=1 (matches the flip-flop power-up Q=1), mismatch=0. Also cleared by reset: state=IDLE, pending=000, synchronizers=0, debounced levels=0, counters=0.
- Reset mid-operation: any command in flight is abandoned and J/K drop to 0 on the next edge. The flip-flop itself is not reset.
- Per button, synchronization: two-flop synchronizer.
- Per button, debounce: the counter increments each cycle the synchronized value differs from the debounced level and clears to 0 when they match. When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Per button, command request: a 0→1 transition of the debounced level sets that button's pending bit. Releases (1→0) generate nothing.
- Glitches shorter than DEBOUNCE_CYCLES: ignored.
- Button held through reset: one command is generated after DEBOUNCE_CYCLES, because the debounced level restarts at 0.
- Pending bits: each is cleared only when its command is served; a second press before service merges into the same bit.
- Priority among pending bits: reset > set > toggle. Remaining bits are served on later passes.
- FSM, IDLE: if any pending bit is set, go to DRIVE. On that edge, register J/K for the winning command (reset: J=0,K=1; set: J=1,K=0; toggle: J=1,K=1), clear the winning pending bit, and update expected_q (reset→0, set→1, toggle→~expected_q).
- FSM, DRIVE: lasts exactly 1 cycle with J/K asserted; the flip-flop samples them at the end of this cycle. Next: J=K=0; go to SETTLE if JK_DRV_CHECK_EN is defined, otherwise IDLE.
- FSM, SETTLE: lasts SETTLE_CYCLES cycles, then CHECK.
- FSM, CHECK: lasts 1 cycle. If q_fb != expected_q, set mismatch. Go to IDLE.
- Throughput: one command per 3+SETTLE_CYCLES cycles with checking, one per 2 without.
- J/K are never both 0-then-asserted for more than 1 cycle; toggles therefore flip the flip-flop exactly once.
- mismatch: sticky until rst.
- Latency: a raw press held steady from cycle 0 gives J/K asserted in cycle DEBOUNCE_CYCLES+4, when the FSM is IDLE with no other pending bit.
- Simultaneous events: presses debouncing on the same cycle set multiple pending bits and are served by priority. A new edge during busy sets its pending bit without disturbing the current command.

Optional Feature:
- Macro: JK_DRV_CHECK_EN.
- Defined: SETTLE and CHECK states exist; mismatch is live as described above.
- Undefined: DRIVE returns directly to IDLE, q_fb is unused, and mismatch is tied to 0. expected_q is still maintained.

Test Plan:
- DEBOUNCE_CYCLES=4, btn_set held high from cycle 0, flip-flop at Q=0 → J=1,K=0 in cycle 8 only; expected_q=1; Q=1 afterwards; mismatch=0.
- btn_toggle bounces 1,0,1,0 on single cycles, then stays low → no J/K activity; pending stays 000.
- btn_set and btn_reset debounce on the same cycle, Q=1 → reset pulse (J=0,K=1) first, set pulse second; final expected_q=1 and Q=1.
- Three separate toggle presses starting from power-up (Q=1) → three single-cycle J=K=1 pulses; Q and expected_q both end at 0.
- JK_DRV_CHECK_EN defined, q_fb forced to 0 after a set command → mismatch=1 in the cycle after CHECK, and it stays 1 until rst.
- rst asserted during DRIVE → J=K=0, busy=0, expected_q=1 after the edge; pending=000; held button produces a new command DEBOUNCE_CYCLES+4 cycles after rst deasserts.
